// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet assembler and clamped cursor tracker.
// Exposes status, X, Y and wheel as 16-bit read registers.
module ps2_mouse_tracker #(
  parameter int POS_W       = 16,
  parameter int X_MIN       = 64,
  parameter int X_MAX       = 474,
  parameter int Y_MIN       = 48,
  parameter int Y_MAX       = 356,
  parameter int X_INIT      = 268,
  parameter int Y_INIT      = 201,
  parameter int WHEEL       = 0,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_err,
  input  logic [1:0]  addr,
  output logic [15:0] data,
  output logic        dav,
  output logic        ack_seen
);

  localparam int SW = POS_W + 2;
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic signed [SW-1:0] X_LO = SW'(X_MIN);
  localparam logic signed [SW-1:0] X_HI = SW'(X_MAX);
  localparam logic signed [SW-1:0] Y_LO = SW'(Y_MIN);
  localparam logic signed [SW-1:0] Y_HI = SW'(Y_MAX);

  typedef enum logic [2:0] {
    WAIT_ACK,
    B0,
    B1,
    B2,
    B3
  } state_t;

  state_t           state;
  logic [POS_W-1:0] pos_x;
  logic [POS_W-1:0] pos_y;
  logic [7:0]       status;
  logic [7:0]       wheel_acc;
  logic [3:0]       err_cnt;
  logic [CW-1:0]    tmo_cnt;
  logic [7:0]       st_b;
  logic [7:0]       dx_b;
  logic [7:0]       dy_b;

  logic                good;
  logic                last;
  logic                busy;
  logic [7:0]          dy_fin;
  logic [7:0]          dz_ext;
  logic signed [8:0]   dx9;
  logic signed [8:0]   dy9;
  logic signed [SW-1:0] nx;
  logic signed [SW-1:0] ny;
  logic [POS_W-1:0]    cx;
  logic [POS_W-1:0]    cy;
  logic [3:0]          err_nxt;

  always_comb begin
    good    = rx_valid & ~rx_err;
    busy    = (state == B1) || (state == B2) || (state == B3);
    last    = good && ((state == B3) || (WHEEL == 0 && state == B2));
    // In 3-byte mode dy is the byte arriving on the completing cycle
    dy_fin  = (WHEEL != 0) ? dy_b : rx_data;
    dx9     = st_b[6] ? 9'sd0 : signed'({st_b[4], dx_b});
    dy9     = st_b[7] ? 9'sd0 : signed'({st_b[5], dy_fin});
    nx      = signed'({2'b00, pos_x}) + SW'(dx9);
    ny      = signed'({2'b00, pos_y}) - SW'(dy9);
    dz_ext  = {{4{rx_data[3]}}, rx_data[3:0]};
    err_nxt = (err_cnt == 4'hF) ? err_cnt : err_cnt + 4'd1;
    if (nx < X_LO)      cx = POS_W'(X_MIN);
    else if (nx > X_HI) cx = POS_W'(X_MAX);
    else                cx = nx[POS_W-1:0];
    if (ny < Y_LO)      cy = POS_W'(Y_MIN);
    else if (ny > Y_HI) cy = POS_W'(Y_MAX);
    else                cy = ny[POS_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_ACK;
      pos_x     <= POS_W'(X_INIT);
      pos_y     <= POS_W'(Y_INIT);
      status    <= '0;
      wheel_acc <= '0;
      err_cnt   <= '0;
      tmo_cnt   <= '0;
      dav       <= 1'b0;
      ack_seen  <= 1'b0;
      st_b      <= '0;
      dx_b      <= '0;
      dy_b      <= '0;
    end else begin
      dav     <= 1'b0;
      tmo_cnt <= (rx_valid || !busy) ? '0 : tmo_cnt + 1'b1;
      unique case (state)
        WAIT_ACK: begin
          if (good && rx_data == 8'hFA) begin
            state    <= B0;
            ack_seen <= 1'b1;
          end
        end
        B0: begin
          if (rx_valid) begin
            if (!rx_err && rx_data[3]) begin
              st_b  <= rx_data;
              state <= B1;
            end else begin
              err_cnt <= err_nxt;
            end
          end
        end
        default: begin
          if (rx_valid && rx_err) begin
            state   <= B0;
            err_cnt <= err_nxt;
          end else if (good) begin
            if (state == B1) begin
              dx_b  <= rx_data;
              state <= B2;
            end else if (state == B2 && WHEEL != 0) begin
              dy_b  <= rx_data;
              state <= B3;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state   <= B0;
            err_cnt <= err_nxt;
          end
        end
      endcase
      if (last) begin
        status <= st_b;
        pos_x  <= cx;
        pos_y  <= cy;
        if (WHEEL != 0) wheel_acc <= wheel_acc + dz_ext;
        dav    <= 1'b1;
        state  <= B0;
      end
    end
  end

  always_comb begin
    unique case (addr)
      2'd0:    data = {ack_seen, 3'b000, err_cnt, status};
      2'd1:    data = 16'(pos_x);
      2'd2:    data = 16'(pos_y);
      default: data = {8'h00, wheel_acc};
    endcase
  end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Scoreboard bench for ps2_mouse_tracker: 3-byte and wheel instances
// against a packet-queue reference model.
module tb_ps2_mouse_tracker;

  localparam int TMO = 40;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_v;
  logic        rx_err;
  logic [1:0]  addr;
  logic        rx_valid0;
  logic        rx_valid1;
  logic [15:0] data0;
  logic [15:0] data1;
  logic        dav0;
  logic        dav1;
  logic        ack0;
  logic        ack1;
  bit          sel;

  assign rx_valid0 = rx_v && !sel;
  assign rx_valid1 = rx_v && sel;

  ps2_mouse_tracker #(.WHEEL(0), .TIMEOUT_CYC(TMO)) dut0 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid0),
    .rx_err(rx_err), .addr(addr), .data(data0), .dav(dav0),
    .ack_seen(ack0)
  );

  ps2_mouse_tracker #(.WHEEL(1), .TIMEOUT_CYC(TMO)) dut1 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid1),
    .rx_err(rx_err), .addr(addr), .data(data1), .dav(dav1),
    .ack_seen(ack1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    bit          s;
    logic [15:0] r0;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [15:0] r3;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;

  // reference model state
  bit         m_ack;
  int         m_err;
  int         m_x;
  int         m_y;
  int         m_whl;
  logic [7:0] m_st;
  logic [7:0] pkt[$];
  int         pend;

  task automatic check(input string n, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", n, act, act, exp, exp);
    end
  endtask

  function automatic logic [15:0] m_r0();
    return {m_ack, 3'b000, 4'(m_err), m_st};
  endfunction

  function automatic void m_reset();
    m_ack = 0; m_err = 0; m_x = 268; m_y = 201; m_whl = 0;
    m_st = 8'h00; pkt.delete(); pend = 0;
  endfunction

  function automatic void err_inc();
    if (m_err < 15) m_err++;
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic void apply_pkt();
    int dx, dy, dz;
    exp_t e;
    dx = int'(pkt[1]); if (pkt[0][4]) dx -= 256; if (pkt[0][6]) dx = 0;
    dy = int'(pkt[2]); if (pkt[0][5]) dy -= 256; if (pkt[0][7]) dy = 0;
    m_x = clampi(m_x + dx, 64, 474);
    m_y = clampi(m_y - dy, 48, 356);
    if (sel) begin
      dz = int'(pkt[3]) % 16;
      if (dz >= 8) dz -= 16;
      m_whl = (m_whl + dz) & 255;
    end
    m_st = pkt[0];
    e.s = sel; e.r0 = m_r0(); e.r1 = 16'(m_x); e.r2 = 16'(m_y); e.r3 = 16'(m_whl);
    expq.push_back(e);
  endfunction

  function automatic bit model_byte(input logic [7:0] b, input bit e);
    if (!m_ack) begin
      if (!e && b == 8'hFA) m_ack = 1;
    end else if (pkt.size() == 0) begin
      if (e || !b[3]) err_inc();
      else pkt.push_back(b);
    end else if (e) begin
      pkt.delete(); err_inc();
    end else begin
      pkt.push_back(b);
      if (pkt.size() == (sel ? 4 : 3)) begin
        apply_pkt(); pkt.delete(); return 1;
      end
    end
    return 0;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    pend += n;
    if (pkt.size() > 0 && pend >= TMO) begin pkt.delete(); err_inc(); end
  endtask

  task automatic send(input logic [7:0] b, input bit e, input int gap);
    bit done;
    repeat (gap) @(posedge clk);
    #1;
    if (pkt.size() > 0 && pend + gap >= TMO) begin pkt.delete(); err_inc(); end
    pend = 0;
    done = model_byte(b, e);
    rx_data = b; rx_err = e; rx_v = 1'b1;
    @(posedge clk);
    #1;
    rx_v = 1'b0; rx_err = 1'b0;
    check("dav_latency", int'(sel ? dav1 : dav0), int'(done));
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a, 0, 0); send(b, 0, 0); send(c, 0, 0);
  endtask

  task automatic check_all(input string n, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3);
    @(posedge clk);
    pend++;
    addr = 2'd0; #1; check({n, "_r0"}, int'(sel ? data1 : data0), int'(e0));
    addr = 2'd1; #1; check({n, "_x"},  int'(sel ? data1 : data0), int'(e1));
    addr = 2'd2; #1; check({n, "_y"},  int'(sel ? data1 : data0), int'(e2));
    addr = 2'd3; #1; check({n, "_w"},  int'(sel ? data1 : data0), int'(e3));
  endtask

  task automatic check_model(input string n);
    check_all(n, m_r0(), 16'(m_x), 16'(m_y), 16'(m_whl));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
  endtask

  function automatic int rgap();
    int r;
    r = $urandom_range(0, 49);
    return (r == 0) ? TMO - 1 : (r == 1) ? TMO : $urandom_range(0, 2);
  endfunction

  task automatic rand_run(input int npkt);
    logic [7:0] st;
    for (int p = 0; p < npkt; p++) begin
      st = 8'($urandom);
      if ($urandom_range(0, 19) != 0) st[3] = 1'b1;
      if ($urandom_range(0, 3) != 0) st[7:6] = 2'b00;
      send(st, $urandom_range(0, 24) == 0, rgap());
      for (int k = 1; k < (sel ? 4 : 3); k++)
        send(8'($urandom), $urandom_range(0, 24) == 0, rgap());
    end
    idle(TMO + 2);
  endtask

  // monitor: pop and compare whenever either DUT announces a packet
  exp_t        me;
  logic [15:0] mr[4];
  bit          mw;
  always @(negedge clk) begin
    if (!rst && (dav0 || dav1)) begin
      mw = dav1;
      for (int i = 0; i < 4; i++) begin
        addr = 2'(i);
        #1;
        mr[i] = mw ? data1 : data0;
      end
      if (expq.size() == 0) begin
        check("mon_unexpected_dav", 1, 0);
      end else begin
        me = expq.pop_front();
        check("mon_dut_sel", int'(mw), int'(me.s));
        check("mon_status", int'(mr[0]), int'(me.r0));
        check("mon_pos_x", int'(mr[1]), int'(me.r1));
        check("mon_pos_y", int'(mr[2]), int'(me.r2));
        check("mon_wheel", int'(mr[3]), int'(me.r3));
      end
    end
  end

  initial begin
    rst = 1'b1; rx_v = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
    addr = 2'd0; sel = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    do_reset();

    check_all("reset", 16'h0000, 16'd268, 16'd201, 16'h0000);

    send3(8'h08, 8'h05, 8'h03);
    check_all("pre_ack", 16'h0000, 16'd268, 16'd201, 16'h0000);

    send(8'hFA, 0, 0);
    send3(8'h08, 8'h05, 8'h03);
    check_all("first_pkt", 16'h8008, 16'd273, 16'd198, 16'h0000);

    do_reset();
    send(8'hFA, 0, 0);
    for (int i = 0; i < 30; i++) send3(8'h18, 8'hF6, 8'h00);
    check_all("clamp_min", 16'h8018, 16'd64, 16'd201, 16'h0000);
    for (int i = 0; i < 4; i++) send3(8'h08, 8'h7F, 8'h00);
    check_all("clamp_max", 16'h8008, 16'd474, 16'd201, 16'h0000);

    do_reset();
    send(8'hFA, 0, 0);
    send(8'h00, 0, 0);
    send3(8'h08, 8'h01, 8'h01);
    check_all("resync", 16'h8108, 16'd269, 16'd200, 16'h0000);

    do_reset();
    send(8'hFA, 0, 0);
    send(8'h08, 0, 0); send(8'h01, 0, 0);
    idle(TMO);
    send3(8'h08, 8'h02, 8'h00);
    check_all("timeout", 16'h8108, 16'd270, 16'd201, 16'h0000);

    do_reset();
    send(8'hFA, 0, 0);
    send(8'h08, 0, 0); send(8'h01, 0, 0);
    idle(TMO - 1);
    send(8'h00, 0, 0);
    check_all("tmo_edge", 16'h8008, 16'd269, 16'd201, 16'h0000);

    send(8'h08, 0, 0); send(8'h01, 1, 0);
    for (int i = 0; i < 20; i++) send(8'h00, 0, 0);
    check_all("err_sat", 16'h8F08, 16'd269, 16'd201, 16'h0000);

    do_reset();
    send(8'hFA, 0, 0);
    send(8'h08, 0, 0); send(8'h01, 0, 0);
    do_reset();
    send3(8'h08, 8'h02, 8'h00);
    check_all("mid_reset", 16'h0000, 16'd268, 16'd201, 16'h0000);

    do_reset();
    send(8'hFA, 0, 0);
    rand_run(150);
    check_model("rand3");

    sel = 1'b1;
    do_reset();
    send(8'hFA, 0, 0);
    send(8'h08, 0, 0); send3(8'h00, 8'h00, 8'h0F);
    check_all("wheel_neg", 16'h8008, 16'd268, 16'd201, 16'h00FF);
    send(8'h08, 0, 0); send3(8'h00, 8'h00, 8'h02);
    check_all("wheel_pos", 16'h8008, 16'd268, 16'd201, 16'h0001);
    send(8'h08, 0, 0); send(8'h00, 0, 0); send(8'h00, 1, 0);
    check_all("wheel_err", 16'h8108, 16'd268, 16'd201, 16'h0001);
    rand_run(100);
    check_model("rand4");

    idle(5);
    check("scoreboard_drain", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
